// File: rtl/sequenced_control_unit.sv
// Registered, stall-aware control unit: one-cycle decode plus a request/wait sequencer for data memory.
// Define CTRL_TIMEOUT_EN to abort a memory access after MAX_WAIT busy cycles (FAULT state, TIMEOUT flag).
//
// state    | meaning
// RUN      | decode OPCODE every edge the PC is not held
// MEM_REQ  | first cycle of a load/store, PC held unconditionally
// MEM_WAIT | request held until BUSYWAIT drops
// FAULT    | hung access aborted, PC held until reset (CTRL_TIMEOUT_EN only)
module sequenced_control_unit #(
   parameter int OPCODE_WIDTH = 8,
   parameter int MAX_WAIT     = 64
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [OPCODE_WIDTH-1:0] OPCODE,
   input  logic                    INS_BUSYWAIT,
   input  logic                    BUSYWAIT,
   output logic                    WRITEENABLE,
   output logic                    ALUSRC,
   output logic [2:0]              ALUOP,
   output logic                    NEMUX,
   output logic [1:0]              BRANCH,
   output logic                    READ,
   output logic                    WRITE,
   output logic                    WRITESRC,
   output logic                    HOLD,
   output logic                    ILLEGAL,
   output logic                    TIMEOUT
);

   if (OPCODE_WIDTH < 5) begin : g_bad_opcode_width
      $error("OPCODE_WIDTH must be at least 5");
   end
   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("MAX_WAIT must be at least 1");
   end

   typedef struct packed {
      logic       we;
      logic       alusrc;
      logic [2:0] aluop;
      logic       nemux;
      logic [1:0] branch;
      logic       read;
      logic       write;
      logic       writesrc;
   } ctrl_t;

`ifdef CTRL_TIMEOUT_EN
   typedef enum logic [1:0] {S_RUN, S_REQ, S_WAIT, S_FAULT} state_t;
   localparam int CW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0] wait_cnt;
   logic          timeout_r;
`else
   typedef enum logic [1:0] {S_RUN, S_REQ, S_WAIT} state_t;
`endif

   state_t state;
   ctrl_t  ctrl_r;
   ctrl_t  dec;
   logic   legal;
   logic   illegal_r;

   function automatic logic op_legal(input logic [OPCODE_WIDTH-1:0] op);
      return ((op >> 5) == '0) && (op[4:0] <= 5'h11) && (op[4:0] != 5'h0B);
   endfunction

   function automatic ctrl_t decode(input logic [OPCODE_WIDTH-1:0] op);
      ctrl_t c;
      c = '0;
      if (op_legal(op)) begin
         case (op[4:0])
            5'h00: begin c.aluop = 3'b001; c.alusrc = 1'b1; end
            5'h01: begin c.aluop = 3'b001; c.alusrc = 1'b1; c.nemux = 1'b1; end
            5'h02: begin c.aluop = 3'b010; c.alusrc = 1'b1; end
            5'h03: begin c.aluop = 3'b011; c.alusrc = 1'b1; end
            5'h04: begin c.aluop = 3'b000; c.alusrc = 1'b1; end
            5'h05: begin c.aluop = 3'b000; end
            5'h06: begin c.branch = 2'b01; end
            5'h07: begin c.aluop = 3'b001; c.alusrc = 1'b1; c.nemux = 1'b1; c.branch = 2'b10; end
            5'h08: begin c.aluop = 3'b001; c.alusrc = 1'b1; c.nemux = 1'b1; c.branch = 2'b11; end
            5'h09: begin c.aluop = 3'b100; c.alusrc = 1'b1; end
            5'h0A: begin c.aluop = 3'b101; end
            5'h0C: begin c.aluop = 3'b110; end
            5'h0D: begin c.aluop = 3'b111; end
            5'h0E: begin c.alusrc = 1'b1; c.read = 1'b1; c.writesrc = 1'b1; end
            5'h0F: begin c.read = 1'b1; c.writesrc = 1'b1; end
            5'h10: begin c.alusrc = 1'b1; c.write = 1'b1; end
            5'h11: begin c.write = 1'b1; end
            default: c = '0;
         endcase
         // stores and all branch/jump ops never write the register file
         c.we = ~c.write & (c.branch == 2'b00);
      end
      return c;
   endfunction

   always_comb begin
      dec   = decode(OPCODE);
      legal = op_legal(OPCODE);
   end

   always_comb begin
      HOLD = INS_BUSYWAIT | BUSYWAIT | (state == S_REQ);
`ifdef CTRL_TIMEOUT_EN
      HOLD = HOLD | (state == S_FAULT);
`endif
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= S_RUN;
         ctrl_r    <= '0;
         illegal_r <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
         wait_cnt  <= '0;
         timeout_r <= 1'b0;
`endif
      end else begin
         case (state)
            S_RUN: begin
               if (!HOLD) begin
                  ctrl_r    <= dec;
                  illegal_r <= illegal_r | ~legal;
                  state     <= (dec.read | dec.write) ? S_REQ : S_RUN;
               end
            end
            S_REQ: begin
               state <= S_WAIT;
`ifdef CTRL_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            S_WAIT: begin
               // completion ignores INS_BUSYWAIT: only the data memory paces this state
               if (!BUSYWAIT) begin
                  ctrl_r    <= dec;
                  illegal_r <= illegal_r | ~legal;
                  state     <= (dec.read | dec.write) ? S_REQ : S_RUN;
               end
`ifdef CTRL_TIMEOUT_EN
               else begin
                  if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                     state        <= S_FAULT;
                     ctrl_r.read  <= 1'b0;
                     ctrl_r.write <= 1'b0;
                     ctrl_r.we    <= 1'b0;
                     timeout_r    <= 1'b1;
                  end
               end
`endif
            end
`ifdef CTRL_TIMEOUT_EN
            S_FAULT: state <= S_FAULT;
`endif
            default: state <= S_RUN;
         endcase
      end
   end

   assign WRITEENABLE = ctrl_r.we & ~HOLD;
   assign ALUSRC      = ctrl_r.alusrc;
   assign ALUOP       = ctrl_r.aluop;
   assign NEMUX       = ctrl_r.nemux;
   assign BRANCH      = ctrl_r.branch;
   assign READ        = ctrl_r.read;
   assign WRITE       = ctrl_r.write;
   assign WRITESRC    = ctrl_r.writesrc;
   assign ILLEGAL     = illegal_r;
`ifdef CTRL_TIMEOUT_EN
   assign TIMEOUT     = timeout_r;
`else
   assign TIMEOUT     = 1'b0;
`endif

endmodule

// File: tb/tb_sequenced_control_unit.sv
// Directed bench for sequenced_control_unit: spec-level model compared every cycle plus literal spot checks.
// Build with CTRL_TIMEOUT_EN defined to exercise the timeout path.
module tb_sequenced_control_unit;

   localparam int MW = 4;
`ifdef CTRL_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] OPCODE;
   logic       INS_BUSYWAIT, BUSYWAIT;
   logic       WRITEENABLE, ALUSRC, NEMUX, READ, WRITE, WRITESRC, HOLD, ILLEGAL, TIMEOUT;
   logic [2:0] ALUOP;
   logic [1:0] BRANCH;

   always #5 CLK = ~CLK;

   sequenced_control_unit #(.OPCODE_WIDTH(8), .MAX_WAIT(MW)) dut (
      .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INS_BUSYWAIT(INS_BUSYWAIT),
      .BUSYWAIT(BUSYWAIT), .WRITEENABLE(WRITEENABLE), .ALUSRC(ALUSRC), .ALUOP(ALUOP),
      .NEMUX(NEMUX), .BRANCH(BRANCH), .READ(READ), .WRITE(WRITE), .WRITESRC(WRITESRC),
      .HOLD(HOLD), .ILLEGAL(ILLEGAL), .TIMEOUT(TIMEOUT)
   );

   int errors = 0;
   int checks = 0;

   // opcode table written straight from the ISA list
   logic [2:0] t_aluop  [32];
   logic [1:0] t_branch [32];
   bit         t_alusrc [32], t_nemux [32], t_rd [32], t_wr [32], t_ws [32], t_ok [32];

   task automatic row(input int op, input logic [2:0] a, input bit s, input bit n,
                      input logic [1:0] b, input bit rd, input bit wr, input bit ws);
      t_ok[op] = 1; t_aluop[op] = a; t_alusrc[op] = s; t_nemux[op] = n;
      t_branch[op] = b; t_rd[op] = rd; t_wr[op] = wr; t_ws[op] = ws;
   endtask

   task automatic init_table();
      for (int i = 0; i < 32; i++) begin
         t_ok[i] = 0; t_aluop[i] = 0; t_alusrc[i] = 0; t_nemux[i] = 0;
         t_branch[i] = 0; t_rd[i] = 0; t_wr[i] = 0; t_ws[i] = 0;
      end
      row(8'h00, 3'b001, 1, 0, 2'b00, 0, 0, 0);
      row(8'h01, 3'b001, 1, 1, 2'b00, 0, 0, 0);
      row(8'h02, 3'b010, 1, 0, 2'b00, 0, 0, 0);
      row(8'h03, 3'b011, 1, 0, 2'b00, 0, 0, 0);
      row(8'h04, 3'b000, 1, 0, 2'b00, 0, 0, 0);
      row(8'h05, 3'b000, 0, 0, 2'b00, 0, 0, 0);
      row(8'h06, 3'b000, 0, 0, 2'b01, 0, 0, 0);
      row(8'h07, 3'b001, 1, 1, 2'b10, 0, 0, 0);
      row(8'h08, 3'b001, 1, 1, 2'b11, 0, 0, 0);
      row(8'h09, 3'b100, 1, 0, 2'b00, 0, 0, 0);
      row(8'h0A, 3'b101, 0, 0, 2'b00, 0, 0, 0);
      row(8'h0C, 3'b110, 0, 0, 2'b00, 0, 0, 0);
      row(8'h0D, 3'b111, 0, 0, 2'b00, 0, 0, 0);
      row(8'h0E, 3'b000, 1, 0, 2'b00, 1, 0, 1);
      row(8'h0F, 3'b000, 0, 0, 2'b00, 1, 0, 1);
      row(8'h10, 3'b000, 1, 0, 2'b00, 0, 1, 0);
      row(8'h11, 3'b000, 0, 0, 2'b00, 0, 1, 0);
   endtask

   // model: m_mode 0 running, 1 request cycle, 2 waiting on memory, 3 aborted
   int         m_mode, m_busy;
   bit         m_we, m_alusrc, m_nemux, m_rd, m_wr, m_ws, m_ill, m_tmo;
   logic [2:0] m_aluop;
   logic [1:0] m_branch;

   task automatic model_take(input logic [7:0] op);
      if (op < 8'd32 && t_ok[op[4:0]]) begin
         m_aluop = t_aluop[op[4:0]]; m_alusrc = t_alusrc[op[4:0]]; m_nemux = t_nemux[op[4:0]];
         m_branch = t_branch[op[4:0]]; m_rd = t_rd[op[4:0]]; m_wr = t_wr[op[4:0]];
         m_ws = t_ws[op[4:0]];
         m_we = !(op inside {8'h06, 8'h07, 8'h08, 8'h10, 8'h11});
      end else begin
         {m_aluop, m_alusrc, m_nemux, m_branch, m_rd, m_wr, m_ws, m_we} = '0;
         m_ill = 1;
      end
      m_mode = (m_rd || m_wr) ? 1 : 0;
   endtask

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_mode = 0; m_busy = 0; m_ill = 0; m_tmo = 0;
         {m_aluop, m_alusrc, m_nemux, m_branch, m_rd, m_wr, m_ws, m_we} = '0;
      end else if (m_mode == 0) begin
         if (!INS_BUSYWAIT && !BUSYWAIT) model_take(OPCODE);
      end else if (m_mode == 1) begin
         m_mode = 2; m_busy = 0;
      end else if (m_mode == 2) begin
         if (!BUSYWAIT) model_take(OPCODE);
         else if (TMO_EN) begin
            m_busy++;
            if (m_busy >= MW) begin
               m_mode = 3; m_rd = 0; m_wr = 0; m_we = 0; m_tmo = 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit hold_e;
      hold_e = INS_BUSYWAIT | BUSYWAIT | (m_mode == 1) | (m_mode == 3);
      chk("hold", {7'd0, HOLD}, {7'd0, hold_e});
      chk("writeenable", {7'd0, WRITEENABLE}, {7'd0, m_we & ~hold_e});
      chk("alusrc", {7'd0, ALUSRC}, {7'd0, m_alusrc});
      chk("aluop", {5'd0, ALUOP}, {5'd0, m_aluop});
      chk("nemux", {7'd0, NEMUX}, {7'd0, m_nemux});
      chk("branch", {6'd0, BRANCH}, {6'd0, m_branch});
      chk("read", {7'd0, READ}, {7'd0, m_rd});
      chk("write", {7'd0, WRITE}, {7'd0, m_wr});
      chk("writesrc", {7'd0, WRITESRC}, {7'd0, m_ws});
      chk("illegal", {7'd0, ILLEGAL}, {7'd0, m_ill});
      chk("timeout", {7'd0, TIMEOUT}, {7'd0, m_tmo});
   endtask

   // inputs apply for one whole cycle and are sampled at its closing edge
   task automatic step(input logic [7:0] op, input logic ibw, input logic bw);
      @(posedge CLK);
      #1;
      OPCODE = op; INS_BUSYWAIT = ibw; BUSYWAIT = bw;
      @(negedge CLK);
      compare_all();
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1;
      RESET = 1; OPCODE = 0; INS_BUSYWAIT = 0; BUSYWAIT = 0;
      #2;
      compare_all();
      @(negedge CLK);
      RESET = 0;
   endtask

   int rc, hc, wc;
   logic [7:0] sweep [$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      init_table();
      RESET = 1; OPCODE = 0; INS_BUSYWAIT = 0; BUSYWAIT = 0;
      @(negedge CLK);
      @(negedge CLK);
      compare_all();
      chk("rst_we", {7'd0, WRITEENABLE}, 8'd0);
      chk("rst_hold", {7'd0, HOLD}, 8'd0);
      chk("rst_aluop", {5'd0, ALUOP}, 8'd0);
      RESET = 0;

      // SUB decoded one cycle after sampling
      step(8'h01, 0, 0);
      step(8'h01, 0, 0);
      chk("sub_aluop", {5'd0, ALUOP}, 8'd1);
      chk("sub_nemux", {7'd0, NEMUX}, 8'd1);
      chk("sub_alusrc", {7'd0, ALUSRC}, 8'd1);
      chk("sub_we", {7'd0, WRITEENABLE}, 8'd1);
      chk("sub_branch", {6'd0, BRANCH}, 8'd0);
      chk("sub_hold", {7'd0, HOLD}, 8'd0);

      // LWD with three busy cycles after the request cycle
      step(8'h0E, 0, 0);
      rc = 0; hc = 0; wc = 0;
      for (int i = 0; i < 5; i++) begin
         step(8'h00, 0, (i >= 1 && i <= 3));
         rc += READ; hc += HOLD; wc += WRITEENABLE;
      end
      chk("lwd_writesrc", {7'd0, WRITESRC}, 8'd1);
      chk("lwd_final_we", {7'd0, WRITEENABLE}, 8'd1);
      chk("lwd_read_cycles", rc[7:0], 8'd5);
      chk("lwd_hold_cycles", hc[7:0], 8'd4);
      chk("lwd_we_cycles", wc[7:0], 8'd1);
      step(8'h00, 0, 0);
      chk("lwd_done_read", {7'd0, READ}, 8'd0);

      // SWI
      step(8'h11, 0, 0);
      wc = 0;
      step(8'h00, 0, 0);
      wc += WRITEENABLE;
      chk("swi_write", {7'd0, WRITE}, 8'd1);
      chk("swi_alusrc", {7'd0, ALUSRC}, 8'd0);
      step(8'h00, 0, 1);
      wc += WRITEENABLE;
      step(8'h00, 0, 0);
      wc += WRITEENABLE;
      chk("swi_we_cycles", wc[7:0], 8'd0);
      step(8'h00, 0, 0);
      chk("swi_done_write", {7'd0, WRITE}, 8'd0);

      // illegal opcode is sticky
      step(8'h0B, 0, 0);
      step(8'h00, 0, 0);
      chk("ill_flag", {7'd0, ILLEGAL}, 8'd1);
      chk("ill_aluop", {5'd0, ALUOP}, 8'd0);
      chk("ill_alusrc", {7'd0, ALUSRC}, 8'd0);
      step(8'h00, 0, 0);
      chk("ill_sticky", {7'd0, ILLEGAL}, 8'd1);
      chk("ill_next_aluop", {5'd0, ALUOP}, 8'd1);

      // opcode sweep, memory ops completed with one busy cycle
      for (int i = 0; i < 20; i++) sweep.push_back(8'(i));
      sweep.push_back(8'h25);
      sweep.push_back(8'h8E);
      sweep.push_back(8'hFF);
      foreach (sweep[k]) begin
         step(sweep[k], 0, 0);
         if (sweep[k] inside {8'h0E, 8'h0F, 8'h10, 8'h11}) begin
            step(8'h00, 0, 1);
            step(8'h00, 0, 0);
         end
      end

      // instruction memory stall freezes decode; both busy holds too
      do_reset();
      step(8'h02, 0, 0);
      step(8'h03, 1, 0);
      chk("freeze_we", {7'd0, WRITEENABLE}, 8'd0);
      step(8'h03, 1, 1);
      step(8'h03, 0, 0);
      chk("freeze_aluop", {5'd0, ALUOP}, 8'd2);
      step(8'h05, 0, 0);
      chk("unfreeze_aluop", {5'd0, ALUOP}, 8'd3);

      // wait completes on BUSYWAIT alone even with INS_BUSYWAIT high
      step(8'h0F, 0, 0);
      step(8'h00, 0, 0);
      step(8'h09, 1, 0);
      chk("wait_ibw_hold", {7'd0, HOLD}, 8'd1);
      step(8'h00, 0, 0);
      chk("wait_ibw_next", {5'd0, ALUOP}, 8'd4);

      // asynchronous reset in the middle of a load
      step(8'h0E, 0, 0);
      step(8'h00, 0, 0);
      step(8'h00, 0, 1);
      chk("pre_rst_read", {7'd0, READ}, 8'd1);
      #1;
      RESET = 1;
      #1;
      compare_all();
      chk("midrst_read", {7'd0, READ}, 8'd0);
      chk("midrst_we", {7'd0, WRITEENABLE}, 8'd0);
      @(negedge CLK);
      BUSYWAIT = 0;
      RESET = 0;
      step(8'h04, 0, 0);
      step(8'h04, 0, 0);
      chk("midrst_run_alusrc", {7'd0, ALUSRC}, 8'd1);
      chk("midrst_run_we", {7'd0, WRITEENABLE}, 8'd1);

      // stuck memory
      step(8'h0E, 0, 0);
      step(8'h00, 0, 0);
      for (int i = 0; i < MW + 6; i++) step(8'h00, 0, 1);
`ifdef CTRL_TIMEOUT_EN
      step(8'h00, 0, 0);
      chk("tmo_flag", {7'd0, TIMEOUT}, 8'd1);
      chk("tmo_read", {7'd0, READ}, 8'd0);
      chk("tmo_hold", {7'd0, HOLD}, 8'd1);
      step(8'h00, 0, 0);
      do_reset();
      chk("tmo_cleared", {7'd0, TIMEOUT}, 8'd0);
`else
      chk("notmo_read", {7'd0, READ}, 8'd1);
      chk("notmo_flag", {7'd0, TIMEOUT}, 8'd0);
      step(8'h00, 0, 0);
`endif
      step(8'h00, 0, 0);
      step(8'h00, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sequenced_control_unit.md
# sequenced_control_unit

Registered, stall-aware successor to the combinational control unit of the single-cycle CPU. It decodes OPCODE into the datapath control bundle one cycle after sampling, and sequences data-memory accesses through an explicit request/wait state machine instead of passing BUSYWAIT straight to HOLD. It flags illegal opcodes and can optionally abort a hung memory access. It sits between the instruction register and the datapath: PC, register file, ALU muxes and data memory.

## Interface
- OPCODE_WIDTH, 8: opcode field width; upper bits beyond bit 4 must be zero for a legal opcode.
- MAX_WAIT, 64: consecutive BUSYWAIT-high cycles in MEM_WAIT before timeout. Used only with CTRL_TIMEOUT_EN; legal range is ≥1.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- OPCODE  in  OPCODE_WIDTH  opcode of the current instruction.
- INS_BUSYWAIT  in  1  instruction memory busy.
- BUSYWAIT  in  1  data memory busy.
- WRITEENABLE  out  1  register file write (gated, see Operation).
- ALUSRC  out  1  0 selects immediate, 1 selects register.
- ALUOP  out  3  ALU function select.
- NEMUX  out  1  two's-complement select for operand 2.
- BRANCH  out  2  branch mode: 00 none, 01 J, 10 BEQ, 11 BNE.
- READ, WRITE  out  1 each  data memory request.
- WRITESRC  out  1  0 selects ALU result, 1 selects memory data.
- HOLD  out  1  stalls the PC.
- ILLEGAL  out  1  sticky flag: an unknown opcode was decoded.
- TIMEOUT  out  1  sticky flag: a memory access was aborted.

## Operation
- ISA decode, ALUOP/ALUSRC/NEMUX/BRANCH per opcode:
  - ADD 0x00: 001/1/0/00. SUB 0x01: 001/1/1/00. AND 0x02: 010/1/0/00. OR 0x03: 011/1/0/00.
  - MOV 0x04: 000/1/0/00. LOADI 0x05: 000/0/0/00. J 0x06: 000/0/0/01.
  - BEQ 0x07: 001/1/1/10. BNE 0x08: 001/1/1/11. MULT 0x09: 100/1/0/00.
  - SL 0x0A: 101/0/0/00. SRA 0x0C: 110/0/0/00. ROR 0x0D: 111/0/0/00.
  - LWD 0x0E, LWI 0x0F: 000, ALUSRC 1/0, READ=1, WRITESRC=1.
  - SWD 0x10, SWI 0x11: 000, ALUSRC 1/0, WRITE=1.
- WE register is 1 for all ops except J, BEQ, BNE, SWD and SWI.
- Illegal opcodes (0x0B, ≥0x12): decode to NOP (all signals 0), set ILLEGAL.
- States:
  - RUN: at each edge with HOLD=0, register decode(OPCODE). If the decoded op has READ or WRITE set, go to MEM_REQ; else stay in RUN.
  - MEM_REQ: exactly 1 cycle. READ/WRITE asserted, HOLD forced 1. Go to MEM_WAIT.
  - MEM_WAIT: READ/WRITE held. HOLD = BUSYWAIT. When BUSYWAIT is sampled low, go to RUN and register decode(OPCODE) at that same edge.
  - FAULT (CTRL_TIMEOUT_EN only): READ/WRITE/WE = 0, HOLD = 1. Exit only by reset.
- HOLD = INS_BUSYWAIT | BUSYWAIT | (state==MEM_REQ) | (state==FAULT).
- WRITEENABLE = WE register & ~HOLD. For a load, this yields a single WE pulse in the MEM_WAIT completion cycle.
- INS_BUSYWAIT high in RUN: control registers are frozen; WE is gated to 0.

## Timing
- Decode latency: 1 cycle, from the OPCODE sampling edge to valid controls.
- HOLD is combinational from BUSYWAIT and INS_BUSYWAIT.
- Memory op minimum duration: MEM_REQ + 1 MEM_WAIT = 2 cycles. READ/WRITE fall at the edge that leaves MEM_WAIT.
- Reset (asynchronous, immediate, also mid-access):
  - State goes to RUN.
  - WRITEENABLE, ALUSRC, ALUOP, NEMUX, BRANCH, READ, WRITE, WRITESRC, ILLEGAL and TIMEOUT are all 0.
  - HOLD = INS_BUSYWAIT | BUSYWAIT.
- BUSYWAIT and INS_BUSYWAIT both high: HOLD=1. The state machine advances only on BUSYWAIT.

## Configuration
- CTRL_TIMEOUT_EN defined:
  - A wait counter clears on entry to MEM_WAIT and increments each cycle BUSYWAIT is high.
  - The counter saturates at MAX_WAIT. On the edge where the count reaches MAX_WAIT with BUSYWAIT still high, go to FAULT and set TIMEOUT.
- CTRL_TIMEOUT_EN undefined: no counter and no FAULT state. TIMEOUT is tied to 0. MEM_WAIT waits indefinitely.

## Test plan
- Reset, then OPCODE=0x01 -> next cycle ALUOP=001, NEMUX=1, ALUSRC=1, WRITEENABLE=1, BRANCH=00, HOLD=0.
- OPCODE=0x0E with BUSYWAIT high for 3 cycles after MEM_REQ -> READ high 5 cycles, HOLD high 4 cycles, WRITEENABLE high only in the final cycle, WRITESRC=1.
- OPCODE=0x11 -> WRITE=1, WRITEENABLE=0 throughout, ALUSRC=0. Returns to RUN when BUSYWAIT falls.
- OPCODE=0x0B -> all controls 0, ILLEGAL=1 and stays 1 after a following 0x00, until RESET.
- RESET pulsed while in MEM_WAIT with READ=1 -> READ=0 and WRITEENABLE=0 immediately, state RUN.
- CTRL_TIMEOUT_EN, MAX_WAIT=4, BUSYWAIT stuck high -> after 4 wait cycles TIMEOUT=1, READ=0, HOLD=1 until reset.
